slave_port_initiator: RTL and testbench

- Synthesizable single-lane bus master that drives the slave memory port (S_oe_ram / S_we_ram / S_addr_ram / S_Wdata_ram / S_data_ram_size) of a generated accelerator `main`.
- Consumes Sout_Rdata_ram / Sout_DataRdy from that port.
- Lets host logic or a bench preload and read back accelerator-internal memories through a simple cmd/rsp handshake, one transaction at a time.
- Instantiate one per lane; a 2-lane port uses two instances, with lane k wired to bit slice k.

---
 rtl/slave_port_initiator.sv | 103 ++++++++++
 tb/tb_slave_port_initiator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/slave_port_initiator.sv
// slave_port_initiator: one-lane cmd/rsp master for an accelerator slave memory port; SLAVE_PORT_INITIATOR_TIMEOUT_EN adds a timeout abort
module slave_port_initiator #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [SIZE_W-1:0] cmd_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              S_oe_ram,
  output logic              S_we_ram,
  output logic [ADDR_W-1:0] S_addr_ram,
  output logic [DATA_W-1:0] S_Wdata_ram,
  output logic [SIZE_W-1:0] S_data_ram_size,
  input  logic [DATA_W-1:0] Sout_Rdata_ram,
  input  logic              Sout_DataRdy
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state;
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT out of range");
  end
  // sizes above DATA_W wrap the shifted one out of range, leaving an all-ones mask
  function automatic logic [DATA_W-1:0] mask_of(input logic [SIZE_W-1:0] s);
    mask_of = DATA_W'(((DATA_W+1)'(1) << s) - (DATA_W+1)'(1));
  endfunction
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
  logic [15:0] cnt;
`else
  assign rsp_error = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      S_oe_ram <= 1'b0;
      S_we_ram <= 1'b0;
      S_addr_ram <= '0;
      S_Wdata_ram <= '0;
      S_data_ram_size <= '0;
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
      rsp_error <= 1'b0;
      cnt <= '0;
`endif
    end else
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            S_oe_ram <= ~cmd_we;
            S_we_ram <= cmd_we;
            S_addr_ram <= cmd_addr;
            S_Wdata_ram <= cmd_we ? cmd_wdata & mask_of(cmd_size) : '0;
            S_data_ram_size <= cmd_size;
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
            cnt <= '0;
`endif
            state <= REQ;
          end
        end
        REQ:
          if (Sout_DataRdy) begin
            rsp_rdata <= S_we_ram ? '0 : Sout_Rdata_ram & mask_of(S_data_ram_size);
            rsp_valid <= 1'b1;
            S_oe_ram <= 1'b0;
            S_we_ram <= 1'b0;
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
            rsp_error <= 1'b0;
`endif
            state <= RESP;
          end
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
          else if (cnt == 16'(TIMEOUT - 1)) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            S_oe_ram <= 1'b0;
            S_we_ram <= 1'b0;
            state <= RESP;
          end else cnt <= cnt + 16'd1;
`endif
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_slave_port_initiator.sv
// tb_slave_port_initiator: directed vector table plus hand sequences for latency, backpressure, reset and timeout
module tb_slave_port_initiator;
  logic clock = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0, Sout_Rdata_ram = '0;
  logic [3:0] cmd_size = '0;
  logic cmd_ready, rsp_valid, rsp_error, S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [7:0] rsp_rdata, S_Wdata_ram;
  logic [6:0] S_addr_ram;
  logic [3:0] S_data_ram_size;
  int checks = 0, failures = 0, lat = 1, req_cyc = 0, both_cnt = 0, rsp_cnt = 0;

  slave_port_initiator #(.ADDR_W(7), .DATA_W(8), .SIZE_W(4), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  always #5 clock = ~clock;

  // responder: strobe is sampled on the lat-th edge after the request appears
  always @(posedge clock) req_cyc <= (S_oe_ram || S_we_ram) ? req_cyc + 1 : 0;
  assign Sout_DataRdy = (S_oe_ram || S_we_ram) && (req_cyc >= lat - 1);
  always @(negedge clock) if (S_oe_ram && S_we_ram) both_cnt <= both_cnt + 1;
  always @(posedge clock) if (!reset && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [3:0] size;
    int         lat;
    logic [7:0] ret;
    logic [7:0] exp_wd;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[8];

  task automatic drive(input vec_t v);
    lat = v.lat;
    Sout_Rdata_ram = v.ret;
    cmd_valid = 1'b1;
    cmd_we = v.we;
    cmd_addr = v.addr;
    cmd_wdata = v.wdata;
    cmd_size = v.size;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("rsp_wait_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic run_txn(input vec_t v, input int exp_cyc, input logic exp_err);
    int n = 0;
    drive(v);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
    while ((S_oe_ram || S_we_ram) && n < 100) begin
      chk("req_sig", {S_we_ram, S_oe_ram, S_addr_ram, S_data_ram_size, S_Wdata_ram},
          {v.we, ~v.we, v.addr, v.size, v.exp_wd});
      n++;
      @(negedge clock);
    end
    chk("req_cycles", n, exp_cyc);
    chk("rsp", {rsp_valid, rsp_error, cmd_ready, rsp_rdata}, {1'b1, exp_err, 1'b0, v.exp_rd});
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    vec_t v;
    int base;
    vecs[0] = '{1'b1, 7'h10, 8'hA5, 4'd8,  2, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 7'h10, 8'h00, 4'd4,  2, 8'hA5, 8'h00, 8'h05};
    vecs[2] = '{1'b0, 7'h11, 8'hFF, 4'd0,  1, 8'hFF, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 7'h12, 8'h3C, 4'd15, 1, 8'h00, 8'h3C, 8'h00};
    vecs[4] = '{1'b1, 7'h7F, 8'hFF, 4'd3,  3, 8'h00, 8'h07, 8'h00};
    vecs[5] = '{1'b0, 7'h00, 8'h00, 4'd7,  1, 8'hFF, 8'h00, 8'h7F};
    vecs[6] = '{1'b0, 7'h55, 8'h00, 4'd12, 4, 8'hC3, 8'h00, 8'hC3};
    vecs[7] = '{1'b1, 7'h2A, 8'hFF, 4'd0,  1, 8'h00, 8'h00, 8'h00};

    @(negedge clock);
    chk("reset_outs", {S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, rsp_valid, rsp_error, rsp_rdata}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    foreach (vecs[i]) run_txn(vecs[i], vecs[i].lat, 1'b0);

    // success on the final permitted cycle
    v = '{1'b0, 7'h20, 8'h00, 4'd8, 8, 8'h5A, 8'h00, 8'h5A};
    run_txn(v, 8, 1'b0);
`ifdef SLAVE_PORT_INITIATOR_TIMEOUT_EN
    v = '{1'b0, 7'h21, 8'h00, 4'd8, 1000, 8'h5A, 8'h00, 8'h00};
    run_txn(v, 8, 1'b1);
`endif

    // backpressure: response held, pending command waits
    v = '{1'b0, 7'h10, 8'h00, 4'd8, 2, 8'h3C, 8'h00, 8'h3C};
    drive(v);
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_rsp();
    chk("bp_rdata", {24'd0, rsp_rdata}, 32'h3C);
    v = '{1'b1, 7'h22, 8'h44, 4'd8, 1, 8'h00, 8'h44, 8'h00};
    drive(v);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_hold", {rsp_valid, cmd_ready, S_we_ram, S_oe_ram, rsp_rdata}, {4'b1000, 8'h3C});
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("bp_release", {rsp_valid, cmd_ready, S_we_ram}, 3'b010);
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("bp_accept", {S_we_ram, S_addr_ram, S_Wdata_ram}, {1'b1, 7'h22, 8'h44});
    wait_rsp();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;

    // reset during the second request cycle
    v = '{1'b0, 7'h05, 8'h00, 4'd8, 5, 8'h77, 8'h00, 8'h77};
    drive(v);
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("mid_req1", {31'd0, S_oe_ram}, 32'd1);
    @(negedge clock);
    chk("mid_req2", {31'd0, S_oe_ram}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_async_drop", {S_oe_ram, S_we_ram, rsp_valid}, 3'b000);
    @(negedge clock);
    reset = 1'b0;
    chk("reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clock);
    chk("reset_cmd_ready", {rsp_valid, cmd_ready}, 2'b01);
    run_txn(v, 5, 1'b0);

    // back-to-back writes with a 1-cycle responder
    rsp_ready = 1'b1;
    base = rsp_cnt;
    for (int k = 0; k < 3; k++) begin
      v = '{1'b1, 7'(k), 8'(k + 1), 4'd8, 1, 8'h00, 8'(k + 1), 8'h00};
      drive(v);
      chk("b2b_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clock);
      cmd_valid = 1'b0;
      chk("b2b_req", {S_we_ram, S_oe_ram, S_addr_ram, S_Wdata_ram}, {2'b10, 7'(k), 8'(k + 1)});
      @(negedge clock);
      chk("b2b_rsp", {rsp_valid, rsp_error, rsp_rdata}, {2'b10, 8'h00});
      @(negedge clock);
    end
    rsp_ready = 1'b0;
    chk("b2b_rsp_count", rsp_cnt - base, 3);
    chk("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
